// File: rtl/add_serial.sv
// Digit-serial adder/subtractor: one DIGIT-wide ripple slice is reused for
// WIDTH/DIGIT cycles, least-significant digit first.
module add_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, out_q;
   logic             c_q, carry_q, ovf_q, zero_q, done_q, ready_q;

   logic [DIGIT-1:0] sum_d;
   logic             cout_d, cmsb_d;
   logic [WIDTH-1:0] res_d;

   // Operands shift right each RUN cycle so the slice always sees bits [DIGIT-1:0].
   always_comb begin
      {cout_d, sum_d} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, c_q};
      // Carry into the digit MSB recovered from the sum bit; only meaningful on the last digit.
      cmsb_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum_d[DIGIT-1];
      res_d  = out_q;
      res_d[cnt_q*DIGIT +: DIGIT] = sum_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         out_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  c_q     <= sub | cin;
                  cnt_q   <= '0;
                  state_q <= RUN;
                  ready_q <= 1'b0;
               end
            end
            RUN: begin
               out_q <= res_d;
               c_q   <= cout_d;
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  carry_q <= cout_d;
                  ovf_q   <= cmsb_d ^ cout_d;
                  zero_q  <= (res_d == '0);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready    = ready_q;
   assign out      = out_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
   assign done     = done_q;

endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: directed vectors on a 16/4 instance plus
// parameter-sweep instances (16/1, 16/16, 32/8) checked against a full-width model.
module tb_add_serial;

   typedef struct {
      logic [31:0] o;
      logic        c, v, z;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   function automatic exp_t model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                  input logic ms, input logic mc);
      logic [32:0] mask, s;
      logic [31:0] am, bb;
      exp_t r;
      mask  = (33'h1 << w) - 33'h1;
      am    = ma & mask[31:0];
      bb    = (ms ? ~mb : mb) & mask[31:0];
      s     = {1'b0, am} + {1'b0, bb} + {32'h0, ms | mc};
      r.c   = s[w];
      r.o   = s[31:0] & mask[31:0];
      r.v   = (am[w-1] == bb[w-1]) && (r.o[w-1] != am[w-1]);
      r.z   = (r.o == 32'h0);
      r.cyc = 0;
      return r;
   endfunction

   // ---------------- main instance: WIDTH=16, DIGIT=4 ----------------
   logic        rst, start, sub, cin, ready, carry, overflow, zero, done;
   logic [15:0] a, b, out;
   exp_t        q0[$];
   exp_t        e0;

   add_serial #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .a(a), .b(b),
      .sub(sub), .cin(cin), .out(out), .carry(carry), .overflow(overflow),
      .zero(zero), .done(done)
   );

   always @(negedge clk) begin
      if (!rst && done) begin
         if (q0.size() == 0) begin
            check(1'b0, "unexpected_done", 64'(out), 64'(0));
         end else begin
            e0 = q0.pop_front();
            check({carry, overflow, zero, out} == {e0.c, e0.v, e0.z, e0.o[15:0]}, "result",
                  64'({carry, overflow, zero, out}), 64'({e0.c, e0.v, e0.z, e0.o[15:0]}));
            check(cyc - e0.cyc == 4, "latency", 64'(cyc - e0.cyc), 64'(4));
         end
      end
   end

   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                        input logic icin, input bit push, input logic [15:0] eo,
                        input logic ec, input logic ev, input logic ez, output int acc);
      int t = 0;
      while (!ready && t < 200) begin @(negedge clk); t++; end
      if (!ready) check(1'b0, "ready_timeout", 64'(ready), 64'(1));
      a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
      @(negedge clk);
      acc = cyc;
      if (push) q0.push_back('{o: {16'h0, eo}, c: ec, v: ev, z: ez, cyc: cyc});
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() != 0 || !ready) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check(1'b0, "drain_timeout", 64'(q0.size()), 64'(0));
   endtask

   // ---------------- parameter sweep instances ----------------
   logic [31:0] va[6] = '{32'h1234ABCD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000003, 32'h0000FFFF};
   logic [31:0] vb[6] = '{32'h0F0F0F0F, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000005, 32'h0000FFFF};

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 2) ? 32 : 16;
      localparam int D = (g == 0) ? 1 : (g == 1) ? 16 : 8;
      localparam int N = W / D;
      logic         srst, sstart, ssub, scin, sready, scarry, sovf, szero, sdone;
      logic [W-1:0] sa, sb, sout;
      exp_t         q[$];
      exp_t         em, ep;
      bit           fin = 1'b0;

      add_serial #(.WIDTH(W), .DIGIT(D)) dut (
         .clk(clk), .rst(srst), .start(sstart), .ready(sready), .a(sa), .b(sb),
         .sub(ssub), .cin(scin), .out(sout), .carry(scarry), .overflow(sovf),
         .zero(szero), .done(sdone)
      );

      always @(negedge clk) begin
         if (!srst && sdone) begin
            if (q.size() == 0) begin
               check(1'b0, $sformatf("sweep%0d_unexpected_done", g), 64'(sout), 64'(0));
            end else begin
               em = q.pop_front();
               check({scarry, sovf, szero, 32'(sout)} == {em.c, em.v, em.z, em.o},
                     $sformatf("sweep%0d_result", g),
                     64'({scarry, sovf, szero, 32'(sout)}), 64'({em.c, em.v, em.z, em.o}));
               check(cyc - em.cyc == N, $sformatf("sweep%0d_latency", g),
                     64'(cyc - em.cyc), 64'(N));
            end
         end
      end

      initial begin
         logic [31:0] xa, xb;
         logic        xs, xc;
         int          t;
         srst = 1'b1; sstart = 1'b0; sa = '0; sb = '0; ssub = 1'b0; scin = 1'b0;
         repeat (3) @(negedge clk);
         srst = 1'b0;
         @(negedge clk);
         for (int k = 0; k < 10; k++) begin
            xa = (k < 6) ? va[k] : $urandom;
            xb = (k < 6) ? vb[k] : $urandom;
            xs = k[0];
            xc = k[1];
            t = 0;
            while (!sready && t < 200) begin @(negedge clk); t++; end
            if (!sready) check(1'b0, $sformatf("sweep%0d_ready_timeout", g), 64'(0), 64'(1));
            sa = xa[W-1:0]; sb = xb[W-1:0]; ssub = xs; scin = xc; sstart = 1'b1;
            ep = model(W, xa, xb, xs, xc);
            @(negedge clk);
            ep.cyc = cyc;
            q.push_back(ep);
            sstart = 1'b0;
         end
         t = 0;
         while ((q.size() != 0 || !sready) && t < 400) begin @(negedge clk); t++; end
         if (t >= 400) check(1'b0, $sformatf("sweep%0d_drain_timeout", g), 64'(q.size()), 64'(0));
         fin = 1'b1;
      end
   end

   // ---------------- main directed sequence ----------------
   initial begin
      int acc1, acc2, t;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check({ready, done, carry, overflow, zero, out} == {1'b1, 4'b0, 16'h0}, "reset_state",
            64'({ready, done, carry, overflow, zero, out}), 64'({1'b1, 4'b0, 16'h0}));
      rst = 1'b0;
      @(negedge clk);

      issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1, 16'h5555, 1'b0, 1'b0, 1'b0, acc1);
      check(ready == 1'b0, "ready_low_in_run", 64'(ready), 64'(0));
      drain();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1, acc1);
      drain();
      // Flags from the previous result must hold while the next operation runs.
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 1'b0, acc1);
      check({carry, overflow, zero} == 3'b101, "flags_hold_in_run",
            64'({carry, overflow, zero}), 64'(3'b101));
      issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1, 16'h7FFF, 1'b1, 1'b1, 1'b0, acc1);
      issue(16'h0003, 16'h0005, 1'b1, 1'b0, 1, 16'hFFFE, 1'b0, 1'b0, 1'b0, acc1);
      issue(16'h0005, 16'h0005, 1'b1, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 1'b1, acc1);
      issue(16'h00FF, 16'h0000, 1'b0, 1'b1, 1, 16'h0100, 1'b0, 1'b0, 1'b0, acc1);
      drain();
      repeat (3) @(negedge clk);
      check({done, carry, overflow, zero, out} == {4'b0000, 16'h0100}, "result_hold",
            64'({done, carry, overflow, zero, out}), 64'({4'b0000, 16'h0100}));

      // start during RUN with other operands must be ignored
      issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1, 16'h1000, 1'b0, 1'b0, 1'b0, acc1);
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (6) @(negedge clk);

      // back-to-back: second start lands in the done cycle
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 16'h3333, 1'b0, 1'b0, 1'b0, acc1);
      issue(16'hA000, 16'h6000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1, acc2);
      check(acc2 - acc1 == 5, "b2b_rate", 64'(acc2 - acc1), 64'(5));
      drain();

      // reset mid-RUN: no done, immediate idle
      issue(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, acc1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check({ready, done, out} == {1'b1, 1'b0, 16'h0}, "reset_mid_run",
            64'({ready, done, out}), 64'({1'b1, 1'b0, 16'h0}));
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check({ready, out} == {1'b1, 16'h0}, "idle_after_reset", 64'({ready, out}), 64'({1'b1, 16'h0}));
      issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0, 1'b0, acc1);
      drain();

      t = 0;
      while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && t < 5000) begin
         @(negedge clk); t++;
      end
      if (t >= 5000) check(1'b0, "sweep_timeout", 64'(t), 64'(5000));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
